// File: rtl/ex_result_pipe_pkg.sv
// Shared types and defaults for the execute-to-writeback result pipeline.
// The lane index is the writeback priority: a higher index wins a contested slot.
package ex_result_pipe_pkg;

    localparam int PIPE_LANES  = 3;
    localparam int PIPE_DEPTH  = 3;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ADDR_W = 5;

    localparam int LANE_ALU = 0;
    localparam int LANE_BRU = 1;
    localparam int LANE_LSU = 2;

    typedef struct packed {
        logic [PIPE_DATA_W-1:0] data_buff;
        logic [PIPE_ADDR_W-1:0] rd_buff;
        logic                   wr_en;
        logic                   valid;
        logic                   is_instr2;
    } uv_buff_t;

    typedef struct packed {
        logic                   wren_instr1;
        logic [PIPE_ADDR_W-1:0] rd_addr_instr1;
        logic [PIPE_DATA_W-1:0] rd_data_instr1;
        logic                   wren_instr2;
        logic [PIPE_ADDR_W-1:0] rd_addr_instr2;
        logic [PIPE_DATA_W-1:0] rd_data_instr2;
    } writeback_t;

    // Squash only ever removes instr2 entries; instr1 entries pass regardless.
    function automatic logic claims_slot(uv_buff_t e, logic slot2, logic kill);
        return e.valid & e.wr_en & (e.is_instr2 == slot2) & ~(kill & e.is_instr2);
    endfunction

endpackage

// File: rtl/ex_result_pipe_if.sv
// Bus between the execute lanes, the forwarding unit and the regfile write port.
interface ex_result_pipe_if
    import ex_result_pipe_pkg::*;
#(
    parameter int LANES = PIPE_LANES,
    parameter int DEPTH = PIPE_DEPTH
) ();

    uv_buff_t    lane [LANES];
    uv_buff_t    tap  [LANES][DEPTH];
    writeback_t  wb;
    logic [1:0]  wb_conflict;
    logic [15:0] conflict_cnt;

    modport master (
        output lane,
        input  tap, wb, wb_conflict, conflict_cnt
    );

    modport slave (
        input  lane,
        output tap, wb, wb_conflict, conflict_cnt
    );

endinterface

// File: rtl/ex_result_pipe_stage_reg.sv
// One pipeline slot: holds a result entry; flush invalidates it, squash kills an
// incoming instr2 entry, and a deasserted enable freezes it.
module ex_stage_reg
    import ex_result_pipe_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_en,
    input  logic     i_flush,
    input  logic     i_squash,
    input  uv_buff_t i_d,
    output uv_buff_t o_q
);

    uv_buff_t q_r;

    // Flush beats stall and squash; data/address are left stale on flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_r <= '0;
        end else if (i_flush) begin
            q_r.valid <= 1'b0;
            q_r.wr_en <= 1'b0;
        end else if (i_en) begin
            q_r       <= i_d;
            q_r.valid <= i_d.valid & ~(i_squash & i_d.is_instr2);
        end else begin
            q_r <= q_r;
        end
    end

    assign o_q = q_r;

endmodule

// File: rtl/ex_result_pipe.sv
// Result pipeline: LANES streams of DEPTH registered stages, every stage exposed as a
// forwarding tap, last stage merged into the two regfile write slots by lane priority.
module ex_result_pipe
    import ex_result_pipe_pkg::*;
#(
    parameter int LANES = PIPE_LANES,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [DEPTH-1:0] i_squash,
    ex_result_pipe_if.slave  bus
);

    uv_buff_t    stage_s [LANES][DEPTH];
    logic        advance_s;
    logic        kill_last_s;
    writeback_t  wb_s;
    logic [1:0]  conflict_s;
    logic [1:0]  seen_s;
    logic [15:0] conflict_cnt_r;

    assign advance_s   = ~i_stall;
    assign kill_last_s = i_squash[DEPTH-1] & advance_s;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            uv_buff_t d_s;
            logic     sq_s;

            if (s == 0) begin : g_first
                assign d_s  = bus.lane[l];
                assign sq_s = 1'b0;
            end else begin : g_next
                // The squash bit of the stage being left applies on entry to this one.
                assign d_s  = stage_s[l][s-1];
                assign sq_s = i_squash[s-1];
            end

            ex_stage_reg u_reg (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_en     (advance_s),
                .i_flush  (i_flush),
                .i_squash (sq_s),
                .i_d      (d_s),
                .o_q      (stage_s[l][s])
            );

            assign bus.tap[l][s] = stage_s[l][s];
        end
    end

    // Writeback merge: later (higher) lanes overwrite earlier claimants of the same slot.
    always_comb begin
        wb_s       = '0;
        conflict_s = 2'b00;
        seen_s     = 2'b00;
        for (int l = 0; l < LANES; l++) begin
            logic c1;
            logic c2;
            c1 = claims_slot(stage_s[l][DEPTH-1], 1'b0, kill_last_s);
            c2 = claims_slot(stage_s[l][DEPTH-1], 1'b1, kill_last_s);

            wb_s.wren_instr1    = wb_s.wren_instr1 | c1;
            wb_s.rd_addr_instr1 = c1 ? stage_s[l][DEPTH-1].rd_buff   : wb_s.rd_addr_instr1;
            wb_s.rd_data_instr1 = c1 ? stage_s[l][DEPTH-1].data_buff : wb_s.rd_data_instr1;
            wb_s.wren_instr2    = wb_s.wren_instr2 | c2;
            wb_s.rd_addr_instr2 = c2 ? stage_s[l][DEPTH-1].rd_buff   : wb_s.rd_addr_instr2;
            wb_s.rd_data_instr2 = c2 ? stage_s[l][DEPTH-1].data_buff : wb_s.rd_data_instr2;

            conflict_s = conflict_s | (seen_s & {c2, c1});
            seen_s     = seen_s | {c2, c1};
        end
    end

    // Conflict cycles are counted regardless of stall or flush and stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conflict_cnt_r <= 16'd0;
        end else if ((conflict_s != 2'b00) && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign bus.wb           = wb_s;
    assign bus.wb_conflict  = conflict_s;
    assign bus.conflict_cnt = conflict_cnt_r;

endmodule
